pulse_frame_receiver: RTL and testbench
=======================================

Name: pulse_frame_receiver

Overview:
Downstream consumer of the multichannel pulse counter's serial output. Deserializes count frames from the serial line using the SL strobe and 3-bit channel address, and stores each channel's latest count and overflow flag in a register bank. Also keeps sticky global and RTC overflow flags. Presents a registered read port to the host/test logic.

Parameters:
NUM_CH, 4, number of channel slots in the register bank (valid addresses 0..NUM_CH-1)
COUNT_W, 8, data bits per frame = width of each stored count
ADDR_W, 3, width of the frame address field

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
serial_in  input  1  serial count data, MSB first
sl_in  input  1  frame start strobe
addr_in  input  ADDR_W  channel address, sampled with sl_in
ovf_ch_in  input  1  per-frame channel overflow, sampled with sl_in
ovf_global_in  input  1  global overflow level
ovf_rtc_in  input  1  RTC window overflow level
clr_flags  input  1  clears sticky flags and new_data
rd_addr  input  ADDR_W  read select
rd_count  output  COUNT_W  stored count of rd_addr (registered)
rd_ovf  output  1  stored overflow bit of rd_addr (registered)
new_data  output  NUM_CH  per-channel "updated since clear" bits
frame_done  output  1  one-cycle pulse on commit
frame_err  output  1  one-cycle pulse on aborted/invalid frame
ovf_global_sticky  output  1  sticky ovf_global_in
ovf_rtc_sticky  output  1  sticky ovf_rtc_in

Behaviour:
- Reset (async, any state): FSM=IDLE; all counts, ovf bits, new_data, sticky flags, rd_count, rd_ovf, frame_done, frame_err = 0.
- FSM: IDLE, SHIFT, COMMIT.
- IDLE: sl_in=1 at cycle T -> latch addr_in, ovf_ch_in; bit_cnt=0; go SHIFT. serial_in ignored at T.
- SHIFT: serial_in sampled on cycles T+1..T+COUNT_W, shifted in MSB first. After bit COUNT_W -> COMMIT.
- COMMIT (cycle T+COUNT_W+1): if latched addr < NUM_CH, write count and ovf into that slot, set new_data[addr], pulse frame_done. Otherwise write nothing and pulse frame_err. Return to IDLE, or go to SHIFT if sl_in=1 this cycle (back-to-back frame, no gap needed).
- sl_in=1 during SHIFT: abort current frame (no write), pulse frame_err, restart as a new frame start with the current addr_in/ovf_ch_in.
- Sticky flags: set when input high, cleared by clr_flags. If set and clear occur in the same cycle, set wins. The same priority applies to new_data against a commit.
- Read: rd_count/rd_ovf = slot[rd_addr] one cycle later. rd_addr >= NUM_CH reads 0. A read of a slot being committed in the same cycle returns the old value.
- Counts are never modified except by commit; no arithmetic, no wrap.

Optional Feature:
FRAME_PARITY_EN
- Defined: one even-parity bit follows the data (cycle T+COUNT_W+1); COMMIT moves to T+COUNT_W+2. On parity mismatch: no write, frame_err pulse, no frame_done.
- Undefined: no parity bit; timing as above.

Decomposition:
- Package pulse_rx_pkg: FSM state enum (IDLE/SHIFT/COMMIT), default NUM_CH/COUNT_W/ADDR_W constants, frame-length constant (COUNT_W, +1 with parity).
- Sub-module pulse_rx_shifter: bit counter + shift register + parity accumulator, with a "last bit" output. The FSM, register bank and flags stay in the top module.

Test Plan:
- Reset mid-SHIFT (after 3 bits of a ch1 frame) -> all outputs 0, FSM IDLE; the next clean frame commits normally.
- sl_in with addr=2, ovf_ch=1, bits 0xA5 -> frame_done at T+9; rd_addr=2 gives rd_count=0xA5, rd_ovf=1 one cycle later; new_data=4'b0100.
- Back-to-back frames ch0=0x01 then ch3=0xFF, second sl_in on the COMMIT cycle -> two frame_done pulses 9 cycles apart; slots 0 and 3 correct; new_data=4'b1001.
- sl_in reasserted after 4 bits, then full frame ch1=0x3C -> frame_err pulse, slot1=0x3C, exactly one frame_done.
- Frame addr=5 -> frame_err, no slot changes; rd_addr=5 -> rd_count=0.
- ovf_global_in pulsed while clr_flags is asserted in the same cycle -> ovf_global_sticky=1; clr_flags alone the next cycle -> 0. With FRAME_PARITY_EN: 0xA5 sent with parity 1 -> frame_err, no write.

Source files
------------

// File: rtl/pulse_rx_pkg.sv
// Shared types and constants for the pulse frame receiver.
// Build option: FRAME_PARITY_EN adds one even-parity bit after the data bits.
`timescale 1ns/1ps
package pulse_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_COUNT_W = 8;
  localparam int DEF_ADDR_W  = 3;

`ifdef FRAME_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_LEN = DEF_COUNT_W + PARITY_BITS;

  // Serial bits following the strobe for a given data width.
  function automatic int frame_len(input int count_w);
    return count_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/pulse_rx_shifter.sv
// Bit counter, MSB-first shift register and even-parity accumulator for one frame.
// Build option: FRAME_PARITY_EN enables the parity accumulator; otherwise parity_ok is tied high.
`timescale 1ns/1ps
module pulse_rx_shifter
  import pulse_rx_pkg::*;
#(
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter int FRAME_LEN = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift_en,
  input  logic               serial_in,
  output logic [COUNT_W-1:0] data,
  output logic               last_bit,
  output logic               parity_ok
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      data    <= '0;
    end else if (start) begin
      bit_cnt <= '0;
      data    <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
      // The trailing parity bit, when present, is not part of the count.
      if (bit_cnt < CNT_W'(COUNT_W))
        data <= {data[COUNT_W-2:0], serial_in};
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(FRAME_LEN - 1));

`ifdef FRAME_PARITY_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity <= 1'b0;
    else if (start)
      parity <= 1'b0;
    else if (shift_en)
      parity <= parity ^ serial_in;
  end

  assign parity_ok = ~parity;
`else
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/pulse_frame_receiver.sv
// Deserializes SL-framed channel counts into a register bank with sticky overflow flags.
// Build option: FRAME_PARITY_EN (even-parity bit after data, checked before commit).
`timescale 1ns/1ps
module pulse_frame_receiver
  import pulse_rx_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serial_in,
  input  logic               sl_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               ovf_ch_in,
  input  logic               ovf_global_in,
  input  logic               ovf_rtc_in,
  input  logic               clr_flags,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COUNT_W-1:0] rd_count,
  output logic               rd_ovf,
  output logic [NUM_CH-1:0]  new_data,
  output logic               frame_done,
  output logic               frame_err,
  output logic               ovf_global_sticky,
  output logic               ovf_rtc_sticky,
  output logic [1:0]         state_dbg
);

  localparam int FLEN = frame_len(COUNT_W);
  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  // Handshake-free stream: sl_in marks a frame start, one data bit per cycle after it.
  state_t              state, state_next;
  logic                start, shift_en, commit;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_ovf;
  logic [COUNT_W-1:0]  shift_data;
  logic                last_bit, parity_ok, frame_ok;
  logic [NUM_CH-1:0]   wr_mask;
  logic [COUNT_W-1:0]  count_mem [NUM_CH];
  logic                ovf_mem   [NUM_CH];
  logic [COUNT_W-1:0]  rd_count_next;
  logic                rd_ovf_next;

  pulse_rx_shifter #(
    .COUNT_W   (COUNT_W),
    .FRAME_LEN (FLEN)
  ) u_shifter (
    .clk       (clk),
    .rst       (reset),
    .start     (start),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .data      (shift_data),
    .last_bit  (last_bit),
    .parity_ok (parity_ok)
  );

  assign frame_ok  = ({1'b0, lat_addr} < NUM_CH_L) && parity_ok;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (sl_in) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A strobe mid-frame abandons the partial frame and restarts.
        if (sl_in) begin
          frame_err = 1'b1;
          start     = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (last_bit)
            state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (frame_ok) begin
          commit     = 1'b1;
          frame_done = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
        if (sl_in) begin
          start      = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr <= '0;
      lat_ovf  <= 1'b0;
    end else if (start) begin
      lat_addr <= addr_in;
      lat_ovf  <= ovf_ch_in;
    end
  end

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (commit && (lat_addr == ADDR_W'(i)))
        wr_mask[i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_mem[i] <= '0;
        ovf_mem[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_mask[i]) begin
          count_mem[i] <= shift_data;
          ovf_mem[i]   <= lat_ovf;
        end
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_data          <= '0;
      ovf_global_sticky <= 1'b0;
      ovf_rtc_sticky    <= 1'b0;
    end else begin
      new_data          <= (new_data & ~{NUM_CH{clr_flags}}) | wr_mask;
      ovf_global_sticky <= (ovf_global_sticky & ~clr_flags) | ovf_global_in;
      ovf_rtc_sticky    <= (ovf_rtc_sticky & ~clr_flags) | ovf_rtc_in;
    end
  end

  always_comb begin
    rd_count_next = '0;
    rd_ovf_next   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_count_next = count_mem[i];
        rd_ovf_next   = ovf_mem[i];
      end
    end
  end

  // Reads see the bank contents before any same-cycle commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_count <= rd_count_next;
      rd_ovf   <= rd_ovf_next;
    end
  end

endmodule

// File: tb/tb_pulse_frame_receiver.sv
// Table-driven bench for pulse_frame_receiver plus hand-written multi-cycle sequences.
// Build option: FRAME_PARITY_EN adds the parity bit to every frame and a bad-parity case.
`timescale 1ns/1ps
module tb_pulse_frame_receiver;
  import pulse_rx_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int COUNT_W = 8;
  localparam int ADDR_W  = 3;
  localparam int LAT     = COUNT_W + PARITY_BITS + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               serial_in, sl_in, ovf_ch_in;
  logic               ovf_global_in, ovf_rtc_in, clr_flags;
  logic [ADDR_W-1:0]  addr_in, rd_addr;
  logic [COUNT_W-1:0] rd_count;
  logic               rd_ovf;
  logic [NUM_CH-1:0]  new_data;
  logic               frame_done, frame_err;
  logic               ovf_global_sticky, ovf_rtc_sticky;
  logic [1:0]         state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [COUNT_W-1:0] model_cnt [8];
  logic               model_ovf [8];
  logic [NUM_CH-1:0]  model_nd;
  logic [COUNT_W-1:0] exp_q [$];

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic               ovf;
    logic [COUNT_W-1:0] data;
    logic               exp_done;
    logic               exp_err;
  } vec_t;
  vec_t vecs [7];

  pulse_frame_receiver #(
    .NUM_CH (NUM_CH), .COUNT_W (COUNT_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .serial_in         (serial_in),
    .sl_in             (sl_in),
    .addr_in           (addr_in),
    .ovf_ch_in         (ovf_ch_in),
    .ovf_global_in     (ovf_global_in),
    .ovf_rtc_in        (ovf_rtc_in),
    .clr_flags         (clr_flags),
    .rd_addr           (rd_addr),
    .rd_count          (rd_count),
    .rd_ovf            (rd_ovf),
    .new_data          (new_data),
    .frame_done        (frame_done),
    .frame_err         (frame_err),
    .ovf_global_sticky (ovf_global_sticky),
    .ovf_rtc_sticky    (ovf_rtc_sticky),
    .state_dbg         (state_dbg)
  );

  // Clock and cycle/pulse counters
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      model_cnt[i] = '0;
      model_ovf[i] = 1'b0;
    end
    model_nd = '0;
  endtask

  task automatic model_commit(input logic [ADDR_W-1:0] a, input logic o, input logic [COUNT_W-1:0] d);
    if (a < NUM_CH) begin
      model_cnt[a] = d;
      model_ovf[a] = o;
      model_nd[a]  = 1'b1;
    end
  endtask

  // Leaves the bench at the start of the commit cycle.
  task automatic shift_bits(input logic [COUNT_W-1:0] d, input logic par);
    sl_in = 1'b0;
    for (int i = COUNT_W - 1; i >= 0; i--) begin
      serial_in = d[i];
      tick();
    end
`ifdef FRAME_PARITY_EN
    serial_in = par;
    tick();
`else
    if (par) serial_in = 1'b0;
`endif
    serial_in = 1'b0;
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic o,
                            input logic [COUNT_W-1:0] d, input logic bad_par);
    sl_in     = 1'b1;
    addr_in   = a;
    ovf_ch_in = o;
    serial_in = 1'b1;
    tick();
    shift_bits(d, (^d) ^ bad_par);
  endtask

  task automatic check_read(input logic [ADDR_W-1:0] a, input string name);
    rd_addr = a;
    tick();
    exp_q.push_back((a < NUM_CH) ? model_cnt[a] : '0);
    chk({name, "_count"}, rd_count, exp_q.pop_front());
    chk({name, "_ovf"}, rd_ovf, (a < NUM_CH) ? model_ovf[a] : 1'b0);
  endtask

  initial begin
    int t0, t1, base_done, base_err;
    logic [COUNT_W-1:0] old_val;

    vecs[0] = '{3'd2, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{3'd0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[2] = '{3'd3, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[3] = '{3'd5, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{3'd1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{3'd7, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[6] = '{3'd3, 1'b0, 8'h7E, 1'b1, 1'b0};

    reset = 1'b1; serial_in = 1'b0; sl_in = 1'b0; addr_in = '0; ovf_ch_in = 1'b0;
    ovf_global_in = 1'b0; ovf_rtc_in = 1'b0; clr_flags = 1'b0; rd_addr = '0;
    model_clear();
    tick(); tick();

    chk("rst_state", state_dbg, IDLE);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_rd_ovf", rd_ovf, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_gsticky", ovf_global_sticky, 0);
    chk("rst_rsticky", ovf_rtc_sticky, 0);
    reset = 1'b0;
    tick();

    // Table of single frames
    for (int v = 0; v < 7; v++) begin
      t0 = cyc;
      send_frame(vecs[v].addr, vecs[v].ovf, vecs[v].data, 1'b0);
      chk($sformatf("v%0d_done", v), frame_done, vecs[v].exp_done);
      chk($sformatf("v%0d_err", v), frame_err, vecs[v].exp_err);
      chk($sformatf("v%0d_latency", v), cyc - t0, LAT);
      model_commit(vecs[v].addr, vecs[v].ovf, vecs[v].data);
      tick();
      chk($sformatf("v%0d_new_data", v), new_data, model_nd);
      check_read(vecs[v].addr, $sformatf("v%0d_rd", v));
    end

    // Reset in the middle of a ch1 frame
    sl_in = 1'b1; addr_in = 3'd1; ovf_ch_in = 1'b1;
    tick();
    sl_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'b1;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midrst_state", state_dbg, IDLE);
    chk("midrst_new_data", new_data, 0);
    chk("midrst_rd_count", rd_count, 0);
    chk("midrst_done", frame_done, 0);
    model_clear();
    tick();
    reset = 1'b0;
    serial_in = 1'b0;
    tick();
    check_read(3'd2, "midrst_slot2");
    send_frame(3'd1, 1'b0, 8'h11, 1'b0);
    chk("postrst_done", frame_done, 1);
    model_commit(3'd1, 1'b0, 8'h11);
    tick();
    check_read(3'd1, "postrst_slot1");

    // Back-to-back frames, second strobe on the commit cycle
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; model_nd = '0;
    send_frame(3'd0, 1'b0, 8'h01, 1'b0);
    chk("b2b_done1", frame_done, 1);
    t1 = cyc;
    model_commit(3'd0, 1'b0, 8'h01);
    send_frame(3'd3, 1'b0, 8'hFF, 1'b0);
    chk("b2b_done2", frame_done, 1);
    chk("b2b_spacing", cyc - t1, LAT);
    model_commit(3'd3, 1'b0, 8'hFF);
    tick();
    chk("b2b_new_data", new_data, 4'b1001);
    check_read(3'd0, "b2b_slot0");
    check_read(3'd3, "b2b_slot3");

    // Abort after 4 bits, then a full ch1 frame
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; model_nd = '0;
    base_done = done_cnt;
    base_err  = err_cnt;
    sl_in = 1'b1; addr_in = 3'd1; ovf_ch_in = 1'b0;
    tick();
    sl_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      tick();
    end
    sl_in = 1'b1; addr_in = 3'd1;
    #1;
    chk("abort_err", frame_err, 1);
    tick();
    shift_bits(8'h3C, ^8'h3C);
    chk("abort_done", frame_done, 1);
    model_commit(3'd1, 1'b0, 8'h3C);
    tick();
    chk("abort_done_count", done_cnt - base_done, 1);
    chk("abort_err_count", err_cnt - base_err, 1);
    chk("abort_new_data", new_data, 4'b0010);
    check_read(3'd1, "abort_slot1");

    // Commit racing clr_flags and a read of the same slot
    old_val = model_cnt[2];
    send_frame(3'd2, 1'b0, 8'h42, 1'b0);
    clr_flags = 1'b1;
    rd_addr   = 3'd2;
    tick();
    clr_flags = 1'b0;
    chk("race_new_data", new_data, 4'b0100);
    chk("race_old_read", rd_count, old_val);
    model_commit(3'd2, 1'b0, 8'h42);
    check_read(3'd2, "race_slot2");

    // Sticky flags: set wins over clear, clear alone drops them
    ovf_global_in = 1'b1; clr_flags = 1'b1;
    tick();
    chk("gsticky_set_wins", ovf_global_sticky, 1);
    ovf_global_in = 1'b0;
    tick();
    chk("gsticky_cleared", ovf_global_sticky, 0);
    clr_flags = 1'b0;
    ovf_rtc_in = 1'b1;
    tick();
    ovf_rtc_in = 1'b0;
    tick();
    chk("rsticky_holds", ovf_rtc_sticky, 1);
    chk("gsticky_idle", ovf_global_sticky, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("rsticky_cleared", ovf_rtc_sticky, 0);

`ifdef FRAME_PARITY_EN
    // 0xA5 has even weight, so a parity bit of 1 is wrong
    old_val = model_cnt[2];
    send_frame(3'd2, 1'b1, 8'hA5, 1'b1);
    chk("par_err", frame_err, 1);
    chk("par_no_done", frame_done, 0);
    tick();
    check_read(3'd2, "par_slot2");
    chk("par_unchanged", rd_count, old_val);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
